// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared width default and direction encoding for the up/down counter
package updown_counter_pkg;

   // Width used when an instance does not override it.
   localparam int DEFAULT_WIDTH = 4;

   // Direction encoding of the ud input.
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

endpackage

// File: rtl/updown_counter_if.sv
// rtl/updown_counter_if.sv - direction input and count output of the up/down counter
interface updown_counter_if
   import updown_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             ud;
   logic [WIDTH-1:0] q;

   // The user of the counter drives direction and reads the count.
   modport master (
      output ud,
      input  q
   );

   // The counter reads direction and drives the count.
   modport slave (
      input  ud,
      output q
   );

endinterface

// File: rtl/updown_counter_next.sv
// rtl/updown_counter_next.sv - combinational modulo-2^WIDTH +1/-1 step
module updown_counter_next
   import updown_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] count,
   input  dir_t             dir,
   output logic [WIDTH-1:0] count_next
);

   // Step by one in the selected direction; truncation to WIDTH gives the wrap-around.
   always_comb begin
      count_next = count;
      if (dir == DIR_UP) begin
         count_next = count + WIDTH'(1);
      end else begin
         count_next = count - WIDTH'(1);
      end
   end

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - free-running modulo-2^WIDTH up/down counter with async reset
module updown_counter
   import updown_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   updown_counter_if.slave bus
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   dir_t             dir;

   assign dir = dir_t'(bus.ud);

   updown_counter_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .count      (count_q),
      .dir        (dir),
      .count_next (count_d)
   );

   // Count register: cleared at once by rst, otherwise takes one step per rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // q is the flop output only, so ud never reaches it combinationally.
   assign bus.q = count_q;

   // Sampling-edge checks: ud legal, count known, and every step exactly +1 or -1.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown(bus.ud))
            else $error("updown_counter: ud unknown at sampling edge");
         assert (!$isunknown(count_q))
            else $error("updown_counter: count unknown out of reset");
         assert ((count_d - count_q) == WIDTH'(1) || (count_q - count_d) == WIDTH'(1))
            else $error("updown_counter: step from %0d to %0d is not +/-1", count_q, count_d);
      end
   end

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - directed self-checking bench for updown_counter (WIDTH 4 and 6)
module tb_updown_counter;

   logic clk;
   logic rst;
   logic rst6;

   int n_pass;
   int n_total;
   int exp;

   updown_counter_if #(.WIDTH(4)) bus4 ();
   updown_counter_if #(.WIDTH(6)) bus6 ();

   updown_counter #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   updown_counter #(.WIDTH(6)) dut6 (
      .clk (clk),
      .rst (rst6),
      .bus (bus6)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      rst6    = 1'b1;
      bus4.ud = 1'b0;
      bus6.ud = 1'b0;

      // Reset state of both widths.
      tick();
      tick();
      check("reset_q4", 8'(bus4.q), 8'd0);
      check("reset_q6", 8'(bus6.q), 8'd0);

      // Release and count up to 9.
      rst     = 1'b0;
      bus4.ud = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         check("up_to_9", 8'(bus4.q), 8'(i));
      end

      // Mid-cycle reset clears q without a clock edge.
      #3;
      rst = 1'b1;
      #1;
      check("async_reset", 8'(bus4.q), 8'd0);

      // q holds 0 across edges while rst is high, whatever ud does.
      for (int i = 0; i < 3; i++) begin
         bus4.ud = ~bus4.ud;
         tick();
         check("reset_hold", 8'(bus4.q), 8'd0);
      end

      // Release with ud=0: 15, 14, ..., 0, 15 over 17 edges.
      bus4.ud = 1'b0;
      rst     = 1'b0;
      exp     = 15;
      for (int i = 0; i < 17; i++) begin
         tick();
         check("down_wrap", 8'(bus4.q), 8'(exp));
         exp = (exp == 0) ? 15 : exp - 1;
      end

      // From 15 count up: 0, 1, ..., 15, 0 over 17 edges.
      bus4.ud = 1'b1;
      exp     = 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         check("up_wrap", 8'(bus4.q), 8'(exp));
         exp = (exp == 15) ? 0 : exp + 1;
      end

      // Direction reversal at 5: up to 5, down 4, 3, up 4.
      for (int i = 1; i <= 5; i++) begin
         tick();
      end
      check("rev_at_5", 8'(bus4.q), 8'd5);
      #3;
      bus4.ud = 1'b0;
      tick();
      check("rev_down_4", 8'(bus4.q), 8'd4);
      tick();
      check("rev_down_3", 8'(bus4.q), 8'd3);
      #3;
      bus4.ud = 1'b1;
      tick();
      check("rev_up_4", 8'(bus4.q), 8'd4);

      // Fast toggling from 0 with ud=1 first: 1, 0, 1, 0, ...
      rst = 1'b1;
      #1;
      check("toggle_reset", 8'(bus4.q), 8'd0);
      rst     = 1'b0;
      bus4.ud = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("toggle", 8'(bus4.q), (i % 2 == 0) ? 8'd1 : 8'd0);
         bus4.ud = ~bus4.ud;
      end

      // WIDTH=6: first down edge from reset gives 63, then up gives 0.
      check("w6_pre", 8'(bus6.q), 8'd0);
      bus6.ud = 1'b0;
      rst6    = 1'b0;
      tick();
      check("w6_down_63", 8'(bus6.q), 8'd63);
      bus6.ud = 1'b1;
      tick();
      check("w6_up_0", 8'(bus6.q), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
